// File: rtl/mem_interleaved_burst.sv
// mem_interleaved_burst
//   Banked word memory with single-word writes and burst reads.
//   Storage is split into B = 2^LOGB banks. The low LOGB address bits select
//   the bank and the remaining bits select the row. A write touches only the
//   addressed bank. A burst read streams consecutive addresses with a
//   valid/ready handshake and wraps modulo 2^K.
//
//   Optional feature (macro MEMI_WIDE_READ_EN): adds output rd_wide. It carries
//   the whole row of the current burst address across all banks, with bank 0
//   in the lowest M bits.
//
// Ports
//   clock      : single clock, rising edge
//   resetn     : asynchronous active-low reset (bank contents are preserved)
//   req_valid  : request offered
//   req_ready  : high in IDLE only; a request is taken when both are high
//   req_we     : 1 = single-word write, 0 = burst read
//   req_addr   : word address (bank = low LOGB bits, row = upper bits)
//   req_len    : burst length minus one
//   req_wdata  : write data
//   rd_valid   : rd_data holds a burst word
//   rd_ready   : consumer accepts rd_data
//   rd_data    : current burst word
//   rd_last    : current word is the final word of the burst
//   busy       : burst in progress
//   rd_wide    : full row of the current address (MEMI_WIDE_READ_EN only)
module mem_interleaved_burst #(
    parameter int M    = 8,
    parameter int K    = 11,
    parameter int LOGB = 1,
    parameter int LW   = 4
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [K-1:0]  req_addr,
    input  logic [LW-1:0] req_len,
    input  logic [M-1:0]  req_wdata,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [M-1:0]  rd_data,
    output logic          rd_last,
    output logic          busy
`ifdef MEMI_WIDE_READ_EN
    ,
    output logic [((1 << LOGB) * M)-1:0] rd_wide
`endif
);

    localparam int B     = 1 << LOGB;
    localparam int RW    = K - LOGB;
    localparam int DEPTH = 1 << RW;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t          state_reg;
    logic [K-1:0]    addr_reg;
    logic [LW-1:0]   count_reg;
    logic [LOGB-1:0] sel_reg;
    logic            rd_zero_reg;   // masks the uninitialised bank read registers after reset
    logic            req_ready_reg;
    logic            busy_reg;
    logic            rd_last_reg;

    logic            wr_en;
    logic [LOGB-1:0] wr_bank;
    logic [RW-1:0]   wr_row;
    logic            accept_rd;
    logic            step;
    logic            load_en;
    logic [K-1:0]    load_addr;
    logic [RW-1:0]   load_row;
    logic [B*M-1:0]  bank_flat;

    assign wr_en     = (state_reg == IDLE) && req_valid && req_we;
    assign wr_bank   = req_addr[LOGB-1:0];
    assign wr_row    = req_addr[K-1:LOGB];
    assign accept_rd = (state_reg == IDLE) && req_valid && !req_we;
    // Advance within a burst: handshake on a word that is not the last one.
    assign step      = (state_reg == BURST) && rd_ready && (count_reg != '0);
    assign load_en   = accept_rd || step;
    assign load_addr = accept_rd ? req_addr : (addr_reg + K'(1));
    assign load_row  = load_addr[K-1:LOGB];

    // Every bank reads the same row on each load. This keeps every bank a
    // simple RAM with a registered read port and also provides the wide row.
    // Writes only happen in IDLE and loads only happen on a read acceptance
    // or inside a burst, so a read and a write never share an edge.
    genvar gi;
    generate
        for (gi = 0; gi < B; gi++) begin : g_bank
            logic [M-1:0] mem [0:DEPTH-1];
            logic [M-1:0] bank_q_reg;

            always_ff @(posedge clock) begin
                if (wr_en && (wr_bank == LOGB'(gi))) begin
                    mem[wr_row] <= req_wdata;
                end
                if (load_en) begin
                    bank_q_reg <= mem[load_row];
                end
            end

            assign bank_flat[gi*M +: M] = bank_q_reg;
        end
    endgenerate

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            count_reg     <= '0;
            sel_reg       <= '0;
            rd_zero_reg   <= 1'b1;
            req_ready_reg <= 1'b1;
            busy_reg      <= 1'b0;
            rd_last_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept_rd) begin
                        state_reg     <= BURST;
                        addr_reg      <= req_addr;
                        count_reg     <= req_len;
                        sel_reg       <= req_addr[LOGB-1:0];
                        rd_zero_reg   <= 1'b0;
                        req_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        rd_last_reg   <= (req_len == '0);
                    end
                end
                BURST: begin
                    if (rd_ready) begin
                        if (count_reg != '0) begin
                            addr_reg    <= load_addr;
                            count_reg   <= count_reg - LW'(1);
                            sel_reg     <= load_addr[LOGB-1:0];
                            rd_last_reg <= (count_reg == LW'(1));
                        end else begin
                            state_reg     <= IDLE;
                            req_ready_reg <= 1'b1;
                            busy_reg      <= 1'b0;
                            rd_last_reg   <= 1'b0;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign req_ready = req_ready_reg;
    assign busy      = busy_reg;
    assign rd_valid  = busy_reg;
    assign rd_last   = rd_last_reg;
    assign rd_data   = rd_zero_reg ? '0 : bank_flat[int'(sel_reg)*M +: M];

`ifdef MEMI_WIDE_READ_EN
    assign rd_wide   = rd_zero_reg ? '0 : bank_flat;
`endif

endmodule

// File: tb/tb_mem_interleaved_burst.sv
// Testbench for mem_interleaved_burst (M=8, K=11, LOGB=2, LW=4).
// Reference model: a flat array of 2^K words indexed by the full address.
// Burst words are predicted as ref_mem[(start + i) mod 2^K].
module tb_mem_interleaved_burst;

    localparam int M    = 8;
    localparam int K    = 11;
    localparam int LOGB = 2;
    localparam int LW   = 4;

    logic          clock;
    logic          resetn;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [K-1:0]  req_addr;
    logic [LW-1:0] req_len;
    logic [M-1:0]  req_wdata;
    logic          rd_valid;
    logic          rd_ready;
    logic [M-1:0]  rd_data;
    logic          rd_last;
    logic          busy;
`ifdef MEMI_WIDE_READ_EN
    logic [4*M-1:0] rd_wide;
`endif

    mem_interleaved_burst #(.M(M), .K(K), .LOGB(LOGB), .LW(LW)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_wdata (req_wdata),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .busy      (busy)
`ifdef MEMI_WIDE_READ_EN
        ,
        .rd_wide   (rd_wide)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [M-1:0] ref_mem [0:(1<<K)-1];
    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wide_exp(input logic [K-1:0] a);
        logic [31:0] w;
        logic [1:0]  b2;
        w = '0;
        for (int b = 0; b < 4; b++) begin
            b2 = 2'(b);
            w[b*8 +: 8] = ref_mem[{a[K-1:2], b2}];
        end
        return w;
    endfunction

    task automatic do_write(input logic [K-1:0] a, input logic [M-1:0] d, input bit quiet);
        @(negedge clock);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = a;
        req_wdata = d;
        check("wr_ready", req_ready, 1);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        ref_mem[a] = d;
        if (!quiet) $display("[TB] write addr=0x%03h data=0x%02h", a, d);
    endtask

    task automatic start_read(input logic [K-1:0] a, input logic [LW-1:0] len);
        @(negedge clock);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = a;
        req_len   = len;
        check("rd_req_ready", req_ready, 1);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
    endtask

    // One cycle of a burst: drive rd_ready and optionally a stray write, then
    // check the word presented in this cycle.
    task automatic sample_word(input logic [K-1:0] a, input bit last_exp,
                               input bit rdy, input bit inject);
        @(negedge clock);
        rd_ready = rdy;
        if (inject) begin
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_addr  = 11'h100;
            req_wdata = 8'h55;
        end else begin
            req_valid = 1'b0;
        end
        check("burst_valid", rd_valid, 1);
        check("burst_busy", busy, 1);
        check("burst_req_ready", req_ready, 0);
        check("burst_data", rd_data, ref_mem[a]);
        check("burst_last", rd_last, last_exp);
`ifdef MEMI_WIDE_READ_EN
        check("burst_wide", rd_wide, wide_exp(a));
`endif
    endtask

    // mode 0: always ready, 1: random stalls, 2: 3 stall cycles on the 2nd word
    task automatic do_read(input logic [K-1:0] a, input logic [LW-1:0] len,
                           input int mode, input bit inject);
        logic [K-1:0] cur;
        int n;
        start_read(a, len);
        for (int i = 0; i <= int'(len); i++) begin
            cur = a + K'(i);
            case (mode)
                1:       n = int'($urandom_range(0, 2));
                2:       n = (i == 1) ? 3 : 0;
                default: n = 0;
            endcase
            for (int c = 0; c <= n; c++) begin
                sample_word(cur, (i == int'(len)), (c == n), inject && (c < n));
            end
        end
        @(negedge clock);
        rd_ready  = 1'b0;
        req_valid = 1'b0;
        check("end_valid", rd_valid, 0);
        check("end_last", rd_last, 0);
        check("end_req_ready", req_ready, 1);
        $display("[TB] read addr=0x%03h len=%0d mode=%0d inject=%0d", a, len, mode, inject);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [K-1:0] ra;
        resetn    = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        req_wdata = '0;
        rd_ready  = 1'b0;
        #2;
        check("rst_valid", rd_valid, 0);
        check("rst_data", rd_data, 0);
        check("rst_last", rd_last, 0);
        check("rst_busy", busy, 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        check("post_rst_ready", req_ready, 1);
        check("post_rst_valid", rd_valid, 0);

        // Fill every location so any read is predictable.
        for (int a = 0; a < (1 << K); a++) do_write(K'(a), M'($urandom), 1'b1);
        $display("[TB] filled %0d words", 1 << K);

        // Burst across bank and row boundaries.
        for (int i = 0; i < 8; i++) do_write(11'h3FE + K'(i), 8'h10 + M'(i), 1'b0);
        do_read(11'h3FE, 4'd7, 0, 1'b0);

        // Address wrap.
        do_write(11'h7FF, 8'hAA, 1'b0);
        do_write(11'h000, 8'hBB, 1'b0);
        do_read(11'h7FF, 4'd1, 0, 1'b0);

        // Consumer stall on the second word.
        do_read(11'h200, 4'd3, 2, 1'b0);

        // Write offered during a burst is ignored.
        do_read(11'h300, 4'd3, 2, 1'b1);
        do_read(11'h100, 4'd0, 0, 1'b0);

        // Reset in the middle of a burst.
        start_read(11'h3FE, 4'd7);
        sample_word(11'h3FE, 1'b0, 1'b1, 1'b0);
        sample_word(11'h3FF, 1'b0, 1'b1, 1'b0);
        @(negedge clock);
        rd_ready = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        check("abort_valid", rd_valid, 0);
        check("abort_data", rd_data, 0);
        check("abort_busy", busy, 0);
        check("abort_last", rd_last, 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn   = 1'b1;
        rd_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check("abort_idle_ready", req_ready, 1);
            check("abort_idle_valid", rd_valid, 0);
        end
        rd_ready = 1'b0;
        $display("[TB] reset during burst");
        do_read(11'h3FE, 4'd7, 1, 1'b0);

        // Single-word read of one row.
        for (int i = 0; i < 4; i++) do_write(11'h008 + K'(i), 8'h01 + M'(i), 1'b0);
        do_read(11'h009, 4'd0, 0, 1'b0);

        // Random traffic, biased towards the top of the address space.
        for (int t = 0; t < 60; t++) begin
            ra = ($urandom_range(0, 3) == 0) ? (11'h7F0 + K'($urandom_range(0, 15)))
                                             : K'($urandom);
            if ($urandom_range(0, 1) == 0)
                do_write(ra, M'($urandom), 1'b0);
            else
                do_read(ra, LW'($urandom), int'($urandom_range(0, 1)), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_interleaved_burst.md
MEM_INTERLEAVED_BURST -- requirements
Module: mem_interleaved_burst

Interface
REQ-001 SHALL have parameter M, default 8, word width in bits.
REQ-002 SHALL have parameter K, default 11, address width in bits (capacity 2^K words).
REQ-003 SHALL have parameter LOGB, default 1, log2 of the bank count B=2^LOGB, with 1 <= LOGB < K.
REQ-004 SHALL have parameter LW, default 4, burst-length field width.
REQ-005 SHALL have port clock, input, 1, single clock; all state updates on its rising edge.
REQ-006 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port req_valid, input, 1, request offered.
REQ-008 SHALL have port req_ready, output, 1, request accepted when high with req_valid.
REQ-009 SHALL have port req_we, input, 1, 1=single-word write, 0=burst read.
REQ-010 SHALL have port req_addr, input, K, word address; bank=req_addr[LOGB-1:0], row=req_addr[K-1:LOGB].
REQ-011 SHALL have port req_len, input, LW, read burst length minus one (0 -> 1 word, 2^LW-1 -> 2^LW words).
REQ-012 SHALL have port req_wdata, input, M, write data.
REQ-013 SHALL have port rd_valid, output, 1, rd_data is valid.
REQ-014 SHALL have port rd_ready, input, 1, consumer accepts rd_data.
REQ-015 SHALL have port rd_data, output, M, registered read word.
REQ-016 SHALL have port rd_last, output, 1, current word is the final word of the burst.
REQ-017 SHALL have port busy, output, 1, high while a burst is in progress.

Function
REQ-018 SHALL hold storage as B independent banks of 2^(K-LOGB) words; a write enables only the addressed bank.
REQ-019 SHALL implement the states IDLE and BURST; req_ready=1 only in IDLE; busy=1 only in BURST.
REQ-020 In IDLE, on req_valid & req_we, SHALL write req_wdata to the addressed bank/row at that edge and remain in IDLE (back-to-back writes, one per cycle).
REQ-021 In IDLE, on req_valid & ~req_we, SHALL latch the address and remaining count = req_len, load rd_data from that address, and enter BURST; rd_valid rises the cycle after acceptance (latency 1).
REQ-022 In BURST, rd_valid=1; rd_data and rd_last SHALL hold stable while rd_ready=0.
REQ-023 On rd_valid & rd_ready with remaining count > 0, SHALL increment the address modulo 2^K (0x7FF -> 0x000 for K=11), decrement the count, and load the next word at the same edge, so a burst with rd_ready held high delivers one word per cycle.
REQ-024 rd_last SHALL equal (remaining count == 0) while rd_valid=1, and 0 otherwise.
REQ-025 On a handshake with rd_last=1, SHALL return to IDLE with rd_valid=0 at the next edge.
REQ-026 Requests offered during BURST SHALL be ignored without side effects.
REQ-027 Bank and row boundary crossings within a burst SHALL be transparent to the consumer.

Reset
REQ-028 resetn=0 SHALL immediately force IDLE, rd_valid=0, rd_last=0, rd_data=0, busy=0, req_ready=1 (when resetn is high), and clear the internal address and count.
REQ-029 Reset SHALL NOT clear bank contents; reset during a burst SHALL abort it with no further words delivered.

Configuration
REQ-030 With macro MEMI_WIDE_READ_EN defined, SHALL add output port rd_wide, width B*M, equal to the row of the current burst address across all banks (bank 0 in bits [M-1:0]), registered with the same timing as rd_data.
REQ-031 Without MEMI_WIDE_READ_EN, port rd_wide and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (M=8, K=11, LOGB=2, LW=4)
REQ-032 Write 0x10..0x17 to addresses 0x3FE..0x405, then read 0x3FE with len 7 and rd_ready=1 -> 0x10..0x17 on 8 consecutive cycles, rd_last only on 0x17, then IDLE.
REQ-033 Write 0xAA to 0x7FF and 0xBB to 0x000, then read 0x7FF with len 1 -> 0xAA then 0xBB (address wrap).
REQ-034 Read a 4-word burst with rd_ready=0 for 3 cycles after the 2nd word -> 2nd word held stable, no word skipped or duplicated.
REQ-035 Offer a write of 0x55 to 0x100 during a burst -> req_ready=0; a later read of 0x100 returns its prior value.
REQ-036 Assert resetn=0 mid-burst -> rd_valid=0 and rd_data=0 immediately; after release req_ready=1 and earlier-written data reads back unchanged.
REQ-037 With MEMI_WIDE_READ_EN defined, write 0x01..0x04 to 0x008..0x00B, then read 0x009 with len 0 -> rd_data=0x02 and rd_wide=0x04030201.
